// File: rtl/int_ctrl_pkg.sv
// Shared types and helpers for the prioritised interrupt controller.
//   int_state_t : per-source service state
//   PRIO_IDLE   : run-priority value meaning "nothing is being serviced"
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        INACTIVE    = 2'd0,
        PENDING     = 2'd1,
        ACTIVE      = 2'd2,
        ACTIVE_PEND = 2'd3
    } int_state_t;

    // One past the least urgent priority, so every real priority compares below it.
    function automatic int unsigned PRIO_IDLE(input int unsigned prio_w);
        return 32'd1 << prio_w;
    endfunction

endpackage

// File: rtl/int_source_unit.sv
// Per-source interrupt slice: configuration registers, edge detector and service FSM.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   irq_hw_i        hardware request line of this source
//   irq_sw_i        software trigger pulse of this source
//   cfg_we_i        config write aimed at this source
//   cfg_prio_i/en_i/edge_i  new priority, enable, mode (1 = rising edge)
//   ack_start_i     processor starts servicing this source
//   ack_end_i       processor finishes servicing this source
//   state_o, prio_o current service state and priority
module int_source_unit
    import int_ctrl_pkg::*;
#(
    parameter int unsigned          PRIO_W   = 3,
    parameter logic [PRIO_W-1:0]    RST_PRIO = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              irq_hw_i,
    input  logic              irq_sw_i,
    input  logic              cfg_we_i,
    input  logic [PRIO_W-1:0] cfg_prio_i,
    input  logic              cfg_en_i,
    input  logic              cfg_edge_i,
    input  logic              ack_start_i,
    input  logic              ack_end_i,
    output int_state_t        state_o,
    output logic [PRIO_W-1:0] prio_o
);

    int_state_t        state_q, state_d;
    logic [PRIO_W-1:0] prio_q, prio_d;
    logic              en_q, en_d;
    logic              edge_q, edge_d;
    logic              prev_q, prev_d;

    logic rise;
    logic evt;        // event that arms an idle source
    logic rearm_evt;  // event that may re-arm an active source (held level excluded)

    always_comb begin
        rise      = irq_hw_i & ~prev_q;
        evt       = en_q & ((edge_q ? rise : irq_hw_i) | irq_sw_i);
        rearm_evt = en_q & ((edge_q & rise) | irq_sw_i);

        state_d = state_q;
        unique case (state_q)
            INACTIVE:    if (evt) state_d = PENDING;
            PENDING:     if (ack_start_i) state_d = ACTIVE;
            ACTIVE: begin
                if (ack_end_i)      state_d = rearm_evt ? PENDING : INACTIVE;
                else if (rearm_evt) state_d = ACTIVE_PEND;
            end
            ACTIVE_PEND: if (ack_end_i) state_d = PENDING;
            default:     state_d = INACTIVE;
        endcase

        prio_d = prio_q;
        en_d   = en_q;
        edge_d = edge_q;
        if (cfg_we_i) begin
            prio_d = cfg_prio_i;
            en_d   = cfg_en_i;
            edge_d = cfg_edge_i;
            // Disabling drops any queued request but never aborts a running service.
            if (!cfg_en_i) begin
                if (state_d == PENDING)     state_d = INACTIVE;
                if (state_d == ACTIVE_PEND) state_d = ACTIVE;
            end
        end

        prev_d = irq_hw_i;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= INACTIVE;
            prio_q  <= RST_PRIO;
            en_q    <= 1'b0;
            edge_q  <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            en_q    <= en_d;
            edge_q  <= edge_d;
            prev_q  <= prev_d;
        end
    end

    assign state_o = state_q;
    assign prio_o  = prio_q;

endmodule

// File: rtl/prio_interrupt_controller.sv
// Nestable prioritised interrupt controller.
// Presents the most urgent pending source that can preempt the running priority.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   gie                       global enable, gates presentation only
//   irq_hw, irq_sw            per-source hardware level/edge and software triggers
//   cfg_*                     per-source priority/enable/mode write port
//   ack_start(_id)            processor begins servicing an ID
//   ack_end(_id)              processor finishes servicing an ID
//   int_flag/int_ID/int_priority  registered presented interrupt
//   run_priority              registered most urgent active priority (2**PRIO_W if idle)
module prio_interrupt_controller
    import int_ctrl_pkg::*;
#(
    parameter int unsigned N_SRC  = 32,
    parameter int unsigned PRIO_W = 3,
    parameter int unsigned ID_W   = $clog2(N_SRC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gie,
    input  logic [N_SRC-1:0]  irq_hw,
    input  logic [N_SRC-1:0]  irq_sw,
    input  logic              cfg_we,
    input  logic [ID_W-1:0]   cfg_id,
    input  logic [PRIO_W-1:0] cfg_prio,
    input  logic              cfg_en,
    input  logic              cfg_edge,
    input  logic              ack_start,
    input  logic [ID_W-1:0]   ack_start_id,
    input  logic              ack_end,
    input  logic [ID_W-1:0]   ack_end_id,
    output logic              int_flag,
    output logic [ID_W-1:0]   int_ID,
    output logic [PRIO_W-1:0] int_priority,
    output logic [PRIO_W:0]   run_priority
);

    localparam logic [PRIO_W:0] RunIdle = (PRIO_W+1)'(PRIO_IDLE(PRIO_W));

    int_state_t        src_state [N_SRC];
    logic [PRIO_W-1:0] src_prio  [N_SRC];
    logic [N_SRC-1:0]  cfg_we_vec, ack_start_vec, ack_end_vec;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        assign cfg_we_vec[i]    = cfg_we    && (cfg_id       == ID_W'(i));
        assign ack_start_vec[i] = ack_start && (ack_start_id == ID_W'(i));
        assign ack_end_vec[i]   = ack_end   && (ack_end_id   == ID_W'(i));

        int_source_unit #(
            .PRIO_W   (PRIO_W),
            .RST_PRIO (PRIO_W'((i * (1 << PRIO_W)) / N_SRC))
        ) u_src (
            .clk         (clk),
            .rst         (rst),
            .irq_hw_i    (irq_hw[i]),
            .irq_sw_i    (irq_sw[i]),
            .cfg_we_i    (cfg_we_vec[i]),
            .cfg_prio_i  (cfg_prio),
            .cfg_en_i    (cfg_en),
            .cfg_edge_i  (cfg_edge),
            .ack_start_i (ack_start_vec[i]),
            .ack_end_i   (ack_end_vec[i]),
            .state_o     (src_state[i]),
            .prio_o      (src_prio[i])
        );
    end

    logic [PRIO_W:0]   run_prio;
    logic              best_found;
    logic [PRIO_W-1:0] best_prio;
    logic [ID_W-1:0]   best_id;

    logic              int_flag_q, int_flag_d;
    logic [ID_W-1:0]   int_id_q, int_id_d;
    logic [PRIO_W-1:0] int_prio_q, int_prio_d;
    logic [PRIO_W:0]   run_prio_q;

    always_comb begin
        run_prio = RunIdle;
        for (int i = 0; i < N_SRC; i++) begin
            if ((src_state[i] == ACTIVE || src_state[i] == ACTIVE_PEND) &&
                ({1'b0, src_prio[i]} < run_prio)) begin
                run_prio = {1'b0, src_prio[i]};
            end
        end

        // Ascending scan with strict compare keeps the lowest ID on ties.
        best_found = 1'b0;
        best_prio  = '1;
        best_id    = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_state[i] == PENDING && ({1'b0, src_prio[i]} < run_prio) &&
                (!best_found || src_prio[i] < best_prio)) begin
                best_found = 1'b1;
                best_prio  = src_prio[i];
                best_id    = ID_W'(i);
            end
        end

        int_flag_d = best_found & gie;
        int_id_d   = int_flag_d ? best_id   : '0;
        int_prio_d = int_flag_d ? best_prio : '1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            int_flag_q <= 1'b0;
            int_id_q   <= '0;
            int_prio_q <= '1;
            run_prio_q <= RunIdle;
        end else begin
            int_flag_q <= int_flag_d;
            int_id_q   <= int_id_d;
            int_prio_q <= int_prio_d;
            run_prio_q <= run_prio;
        end
    end

    assign int_flag     = int_flag_q;
    assign int_ID       = int_id_q;
    assign int_priority = int_prio_q;
    assign run_priority = run_prio_q;

endmodule

// File: doc/prio_interrupt_controller.md
# prio_interrupt_controller

Parametrised, nestable interrupt controller. It takes `N_SRC` hardware and software interrupt sources, each with a run-time programmable priority, enable and level/edge mode. It presents the highest-priority pending source to the processor only when that source can preempt the currently running priority, and tracks each source through a start/end acknowledge handshake. It sits between the peripheral flag lines and the processor's interrupt decider.

## Interface
Parameters:
- `N_SRC`, 32, number of interrupt sources (2..64)
- `PRIO_W`, 3, priority field width; numerically lower value = more urgent
- `ID_W`, `$clog2(N_SRC)`, source ID width (derived, not overridden)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `gie`  in  1  global interrupt enable; gates presentation only
- `irq_hw`  in  N_SRC  hardware request lines, one per source
- `irq_sw`  in  N_SRC  software trigger pulses, always edge-like
- `cfg_we`  in  1  config write strobe
- `cfg_id`  in  ID_W  source being configured
- `cfg_prio`  in  PRIO_W  new priority
- `cfg_en`  in  1  new enable
- `cfg_edge`  in  1  new mode: 1 = rising-edge, 0 = level
- `ack_start`, `ack_start_id`  in  1, ID_W  processor begins servicing an ID
- `ack_end`, `ack_end_id`  in  1, ID_W  processor finishes servicing an ID
- `int_flag`  out  1  an interrupt is presented (registered)
- `int_ID`  out  ID_W  presented source (registered)
- `int_priority`  out  PRIO_W  priority of presented source (registered)
- `run_priority`  out  PRIO_W+1  most urgent priority among ACTIVE sources; `2**PRIO_W` when none are active (registered)

## Operation
- Per-source state: INACTIVE, PENDING, ACTIVE, ACTIVE_PEND.
- An event is defined as follows:
  - edge mode: `irq_hw[i]` = 1 with its previous sample = 0;
  - level mode: `irq_hw[i]` = 1;
  - either mode: `irq_sw[i]` = 1.
  - Events are ignored when the source is disabled.
- Transitions:
  - INACTIVE→PENDING on event.
  - PENDING→ACTIVE on a matching `ack_start`.
  - ACTIVE→ACTIVE_PEND on event, edge mode or sw only. A held level does not re-arm while the source is active.
  - ACTIVE→INACTIVE on a matching `ack_end`.
  - ACTIVE_PEND→PENDING on a matching `ack_end`.
  - Event and `ack_end` in the same cycle on ACTIVE → PENDING.
- Ignored acknowledges:
  - `ack_start` to a non-PENDING ID.
  - `ack_end` to a non-ACTIVE/ACTIVE_PEND ID.
- Same ID in `ack_start` and `ack_end` in one cycle: each is evaluated against the current state, so only one applies.
- Arbitration candidate: PENDING sources with `prio < run_priority` (strict). Most urgent wins; ties go to the lowest ID.
- `int_flag` = candidate exists AND `gie`. When `int_flag` = 0, `int_ID` = 0 and `int_priority` = all ones.
- `gie` = 0 does not block event capture or acknowledges.
- Config write applies at the clock edge:
  - Priority and mode change immediately, including for pending or active sources.
  - `cfg_en` = 0 on PENDING → INACTIVE.
  - `cfg_en` = 0 on ACTIVE_PEND → ACTIVE.
  - `cfg_en` = 0 on ACTIVE is left ACTIVE; it completes via `ack_end`.
- Reset values for all sources:
  - state INACTIVE
  - `cfg_en` = 0
  - `cfg_edge` = 0
  - priority of source i = `(i * 2**PRIO_W) / N_SRC`
  - previous-sample register = 0
- Reset values of outputs: `int_flag` = 0, `int_ID` = 0, `int_priority` = all ones, `run_priority` = `2**PRIO_W`.

## Timing
- Event sampled at edge E0 → PENDING after E0 → `int_flag`/`int_ID` valid after E1. Latency is 2 edges.
- `ack_start` at edge E → ACTIVE after E. `int_flag` drops and `run_priority` updates after E+1.
- Outputs are registered from the current state, one cycle behind it. The processor must not re-`ack_start` the same ID in the cycle right after acknowledging.
- Reset asserted mid-service clears all state on that edge. Outputs take their reset values on the same edge.

## Structure
- Package `int_ctrl_pkg`:
  - `int_state_t` enum (2-bit: INACTIVE=0, PENDING=1, ACTIVE=2, ACTIVE_PEND=3)
  - `PRIO_IDLE` helper function
- Sub-module `int_source_unit`: one per source, via generate. It holds the config registers, edge-detect register and state FSM, and outputs state and priority.
- The top level contains:
  - the arbitration loop, written as a combinational tree or loop;
  - the `run_priority` min-reduction;
  - the ack decoders;
  - the output registers.

## Test plan
- Basic service:
  - Stimulus: enable src 5 (prio 1, level), `gie` = 1, pulse `irq_hw[5]`.
  - Response: `int_flag` = 1, `int_ID` = 5, `int_priority` = 1 two cycles later. After `ack_start(5)`, `int_flag` = 0 and `run_priority` = 1. After `ack_end(5)` with `irq_hw[5]` low, `run_priority` = 8.
- Preemption:
  - Stimulus: src 12 ACTIVE at prio 3; raise src 20 (prio 3), then src 2 (prio 0).
  - Response: src 20 is never presented. Src 2 is presented with `int_ID` = 2. After the nested `ack_end(2)`, `run_priority` returns to 3.
- Tie-break:
  - Stimulus: srcs 9 and 7, both prio 2, raised in the same cycle.
  - Response: `int_ID` = 7. After `ack_start(7)`/`ack_end(7)`, `int_ID` = 9.
- Edge re-arm:
  - Stimulus: src 4 in edge mode, ACTIVE; new rising edge arrives.
  - Response: state becomes ACTIVE_PEND. After `ack_end(4)`, src 4 is re-presented.
  - Level mode, held high: re-presented only via INACTIVE→PENDING after `ack_end`.
- Enable, `gie` and reset:
  - A disabled source ignores `irq_sw`.
  - `gie` = 0 while src 3 is PENDING: `int_flag` = 0. `gie` → 1: `int_flag` = 1 next cycle.
  - `cfg_en` = 0 on a PENDING source: source cleared.
  - `rst` = 0 while sources are ACTIVE: all outputs at reset values after that edge.
